id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage ARM-subset pipeline. Sits between the IF stage register and the ID stage register.
- Decodes the 32-bit instruction, evaluates its condition field against the current NZCV flags, and reads operands from the integrated register file.
- The register file is written by the WB stage.
- Produces every field the ID stage register latches, plus hazard-unit signals.

Parameters:
- REG_COUNT, 15, architectural registers held in the file (R0..R14); index 15 is not stored.
- REG_RESET_VALUE, 0, value loaded into every register on reset.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- pc_in  in  LEN_ADDRESS  PC+4 from IF stage register
- instruction  in  32  instruction from IF stage register
- status_reg_in  in  LEN_STATUS(4)  current flags {N,Z,C,V}
- hazard  in  1  stall request from hazard unit
- wb_enable  in  1  WB write request
- wb_dest  in  LEN_REG_ADDRESS(4)  WB destination
- wb_value  in  LEN_REGISTER(32)  WB data
- pc_out  out  LEN_ADDRESS  pc_in passthrough
- reg_file_src1, reg_file_src2  out  4  source register indices
- reg_file_out1, reg_file_out2  out  32  operand values
- signed_immediate  out  24  instruction[23:0]
- shift_operand  out  12  instruction[11:0]
- is_immediate  out  1  instruction[25]
- status_write_enable  out  1  S-bit, gated
- execute_command  out  LEN_EXECUTE_COMMAND(4)  ALU command
- mem_read, mem_write, wb_enable_out, is_branch  out  1  gated controls
- dest_reg  out  4  instruction[15:12]
- two_src  out  1  instruction uses a second register source (for hazard unit)

Behaviour:
- Field map: cond [31:28], mode [27:26], I [25], opcode [24:21], S [20], Rn [19:16], Rd [15:12].
- Register file:
  - REG_COUNT x 32 storage.
  - Write at posedge clk when wb_enable=1 and wb_dest<REG_COUNT. wb_dest=15 is ignored.
  - Reads are combinational. If the read index equals wb_dest and wb_enable=1, the read returns wb_value (write-through bypass, same cycle). Reads of index 15 return 0.
  - rst at any posedge loads REG_RESET_VALUE into all entries; a WB write in that same cycle is discarded.
- Source selection:
  - src1 = Rn.
  - src2 = Rd when mode=01 and S=0 (STR); otherwise instruction[3:0].
- Control decode, mode 00 (data processing), opcode -> execute_command:
  - MOV 1101 -> 0001; MVN 1111 -> 1001; ADD 0100 -> 0010; ADC 0101 -> 0011
  - SUB 0010 -> 0100; SBC 0110 -> 0101; AND 0000 -> 0110; ORR 1100 -> 0111
  - EOR 0001 -> 1000; CMP 1010 -> 0100; TST 1000 -> 0110
  - wb_enable=1 except for CMP and TST. status_write_enable=S.
  - Unlisted opcode: all controls 0, execute_command 0000.
- Control decode, mode 01 (memory): execute_command=0010, status_write_enable=0.
  - S=1 is LDR: mem_read=1, wb_enable=1.
  - S=0 is STR: mem_write=1.
- Control decode, mode 10 (branch): is_branch=1, execute_command=0000, no write-back.
- Control decode, mode 11: no-op, all controls 0.
- Condition check, standard ARM codes 0000 EQ..1110 AL. 1111 is never-execute and evaluates false.
- Gating: if hazard=1 or the condition is false, the following are forced to 0:
  - mem_read, mem_write, wb_enable_out, is_branch, status_write_enable.
  - Data fields and execute_command pass unmodified.
- two_src = (~I) | (mode=01 & S=0). Forced 0 for mode 10.
- Latency: decode and register read are combinational, zero cycles. Register-file write takes effect at the next posedge.
- Outputs after reset with instruction=0: register outputs 0. instruction=0 decodes as AND EQ and is gated by status_reg_in.

Decomposition:
- ISA package holds all widths (LEN_*), opcode and execute-command constants, condition codes, and mode encodings.
- Sub-modules: register_file (storage, reset, bypass), control_unit (opcode/mode decode), condition_check (cond vs NZCV).
- id_stage is glue logic: source selection and gating.

Test Plan:
- Reset, then read R0..R14 -> all 0. Write R15=0xFFFFFFFF -> subsequent read of 15 returns 0.
- wb_enable=1, wb_dest=3, wb_value=0x00001234, and instruction reading Rn=3 in the same cycle -> reg_file_out1=0x00001234 before the edge and after it.
- 0xE0821003 (ADD R1,R2,R3, AL) -> execute_command=0010, wb_enable_out=1, src1=2, src2=3, dest_reg=1, two_src=1.
- 0x00821003 (ADDEQ) with status_reg_in=0000 -> wb_enable_out=0, execute_command=0010. With status_reg_in=0100 -> wb_enable_out=1.
- 0xE5921004 (LDR) -> mem_read=1, wb_enable_out=1, execute_command=0010. Same cycle with hazard=1 -> mem_read=0, wb_enable_out=0.
- 0xE5821004 (STR R1) -> mem_write=1, src2=1, two_src=1. 0xEAFFFFFE (B) -> is_branch=1, signed_immediate=0xFFFFFE.

Source files
------------

// File: rtl/id_stage_pkg.sv
// ISA constants for the ARM-subset decode stage: field widths, opcodes,
// execute commands, condition codes, mode encodings and the control bundle.
package id_stage_pkg;

  localparam int unsigned LEN_ADDRESS         = 32;
  localparam int unsigned LEN_STATUS          = 4;
  localparam int unsigned LEN_REG_ADDRESS     = 4;
  localparam int unsigned LEN_REGISTER        = 32;
  localparam int unsigned LEN_EXECUTE_COMMAND = 4;
  localparam int unsigned LEN_OPCODE          = 4;
  localparam int unsigned LEN_COND            = 4;
  localparam int unsigned LEN_SIGNED_IMM      = 24;
  localparam int unsigned LEN_SHIFT_OPERAND   = 12;

  typedef enum logic [1:0] {
    MODE_DP     = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_NOP    = 2'b11
  } mode_e;

  localparam logic [LEN_OPCODE-1:0] OP_AND = 4'b0000;
  localparam logic [LEN_OPCODE-1:0] OP_EOR = 4'b0001;
  localparam logic [LEN_OPCODE-1:0] OP_SUB = 4'b0010;
  localparam logic [LEN_OPCODE-1:0] OP_ADD = 4'b0100;
  localparam logic [LEN_OPCODE-1:0] OP_ADC = 4'b0101;
  localparam logic [LEN_OPCODE-1:0] OP_SBC = 4'b0110;
  localparam logic [LEN_OPCODE-1:0] OP_TST = 4'b1000;
  localparam logic [LEN_OPCODE-1:0] OP_CMP = 4'b1010;
  localparam logic [LEN_OPCODE-1:0] OP_ORR = 4'b1100;
  localparam logic [LEN_OPCODE-1:0] OP_MOV = 4'b1101;
  localparam logic [LEN_OPCODE-1:0] OP_MVN = 4'b1111;

  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_NOP = 4'b0000;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_MOV = 4'b0001;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_ADD = 4'b0010;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_ADC = 4'b0011;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_SUB = 4'b0100;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_SBC = 4'b0101;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_AND = 4'b0110;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_ORR = 4'b0111;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_EOR = 4'b1000;
  localparam logic [LEN_EXECUTE_COMMAND-1:0] EXE_MVN = 4'b1001;

  typedef enum logic [LEN_COND-1:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic [LEN_EXECUTE_COMMAND-1:0] exe_cmd;
    logic                           mem_read;
    logic                           mem_write;
    logic                           wb_enable;
    logic                           is_branch;
    logic                           status_write;
  } ctrl_t;

endpackage

// File: rtl/id_stage_condition_check.sv
// Evaluates an ARM condition code against the {N,Z,C,V} flags.
module condition_check
  import id_stage_pkg::*;
(
  input  logic [LEN_COND-1:0]   cond,
  input  logic [LEN_STATUS-1:0] status,
  output logic                  cond_ok
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage_control_unit.sv
// Mode/opcode decode into execute command and ungated pipeline controls.
module control_unit
  import id_stage_pkg::*;
(
  input  logic [1:0]            mode,
  input  logic [LEN_OPCODE-1:0] opcode,
  input  logic                  s_bit,
  output ctrl_t                 ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (mode_e'(mode))
      MODE_DP: begin
        ctrl.wb_enable    = 1'b1;
        ctrl.status_write = s_bit;
        unique case (opcode)
          OP_MOV:  ctrl.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl.exe_cmd = EXE_SBC;
          OP_AND:  ctrl.exe_cmd = EXE_AND;
          OP_ORR:  ctrl.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl.exe_cmd   = EXE_SUB;
            ctrl.wb_enable = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd   = EXE_AND;
            ctrl.wb_enable = 1'b0;
          end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd   = EXE_ADD;
        ctrl.mem_read  = s_bit;
        ctrl.wb_enable = s_bit;
        ctrl.mem_write = ~s_bit;
      end
      MODE_BRANCH: ctrl.is_branch = 1'b1;
      default:     ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_register_file.sv
// Architectural register file: synchronous reset/write, combinational reads
// with same-cycle write-through from the WB port.
module register_file
  import id_stage_pkg::*;
#(
  parameter int unsigned              REG_COUNT       = 15,
  parameter logic [LEN_REGISTER-1:0]  REG_RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LEN_REG_ADDRESS-1:0] src1,
  input  logic [LEN_REG_ADDRESS-1:0] src2,
  input  logic                       wb_enable,
  input  logic [LEN_REG_ADDRESS-1:0] wb_dest,
  input  logic [LEN_REGISTER-1:0]    wb_value,
  output logic [LEN_REGISTER-1:0]    out1,
  output logic [LEN_REGISTER-1:0]    out2
);

  logic [LEN_REGISTER-1:0] regs_q [REG_COUNT];
  logic [LEN_REGISTER-1:0] regs_d [REG_COUNT];

  // Reset wins over a coincident WB write; unstored indices are never written.
  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_d[i] = REG_RESET_VALUE;
      end
    end else if (wb_enable && (32'(wb_dest) < REG_COUNT)) begin
      regs_d[wb_dest] = wb_value;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    out1 = '0;
    out2 = '0;
    if (32'(src1) < REG_COUNT) begin
      out1 = (wb_enable && (src1 == wb_dest)) ? wb_value : regs_q[src1];
    end
    if (32'(src2) < REG_COUNT) begin
      out2 = (wb_enable && (src2 == wb_dest)) ? wb_value : regs_q[src2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: field extraction, source selection, register
// read and condition/hazard gating of side-effecting controls.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned             REG_COUNT       = 15,
  parameter logic [LEN_REGISTER-1:0] REG_RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LEN_ADDRESS-1:0]         pc_in,
  input  logic [31:0]                    instruction,
  input  logic [LEN_STATUS-1:0]          status_reg_in,
  input  logic                           hazard,
  input  logic                           wb_enable,
  input  logic [LEN_REG_ADDRESS-1:0]     wb_dest,
  input  logic [LEN_REGISTER-1:0]        wb_value,
  output logic [LEN_ADDRESS-1:0]         pc_out,
  output logic [LEN_REG_ADDRESS-1:0]     reg_file_src1,
  output logic [LEN_REG_ADDRESS-1:0]     reg_file_src2,
  output logic [LEN_REGISTER-1:0]        reg_file_out1,
  output logic [LEN_REGISTER-1:0]        reg_file_out2,
  output logic [LEN_SIGNED_IMM-1:0]      signed_immediate,
  output logic [LEN_SHIFT_OPERAND-1:0]   shift_operand,
  output logic                           is_immediate,
  output logic                           status_write_enable,
  output logic [LEN_EXECUTE_COMMAND-1:0] execute_command,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic                           wb_enable_out,
  output logic                           is_branch,
  output logic [LEN_REG_ADDRESS-1:0]     dest_reg,
  output logic                           two_src
);

  logic [1:0] mode;
  logic       s_bit;
  logic       is_store;
  logic       cond_ok;
  logic       pass;
  ctrl_t      ctrl;

  assign mode     = instruction[27:26];
  assign s_bit    = instruction[20];
  assign is_store = (mode == MODE_MEM) && !s_bit;

  assign pc_out           = pc_in;
  assign signed_immediate = instruction[23:0];
  assign shift_operand    = instruction[11:0];
  assign is_immediate     = instruction[25];
  assign dest_reg         = instruction[15:12];
  assign reg_file_src1    = instruction[19:16];
  // STR reads the stored value from Rd, so it needs Rd on the second port.
  assign reg_file_src2    = is_store ? instruction[15:12] : instruction[3:0];
  assign two_src          = (mode != MODE_BRANCH) && (~instruction[25] || is_store);

  register_file #(
    .REG_COUNT       (REG_COUNT),
    .REG_RESET_VALUE (REG_RESET_VALUE)
  ) u_register_file (
    .clk       (clk),
    .rst       (rst),
    .src1      (reg_file_src1),
    .src2      (reg_file_src2),
    .wb_enable (wb_enable),
    .wb_dest   (wb_dest),
    .wb_value  (wb_value),
    .out1      (reg_file_out1),
    .out2      (reg_file_out2)
  );

  control_unit u_control_unit (
    .mode   (mode),
    .opcode (instruction[24:21]),
    .s_bit  (s_bit),
    .ctrl   (ctrl)
  );

  condition_check u_condition_check (
    .cond    (instruction[31:28]),
    .status  (status_reg_in),
    .cond_ok (cond_ok)
  );

  // A stalled or condition-failed instruction must not cause side effects.
  assign pass                = cond_ok & ~hazard;
  assign execute_command     = ctrl.exe_cmd;
  assign mem_read            = ctrl.mem_read     & pass;
  assign mem_write           = ctrl.mem_write    & pass;
  assign wb_enable_out       = ctrl.wb_enable    & pass;
  assign is_branch           = ctrl.is_branch    & pass;
  assign status_write_enable = ctrl.status_write & pass;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table through a scoreboard
// queue, plus register-file reset, write, bypass and R15 sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic [3:0]  status_reg_in;
  logic        hazard;
  logic        wb_enable;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [31:0] pc_out;
  logic [3:0]  reg_file_src1, reg_file_src2;
  logic [31:0] reg_file_out1, reg_file_out2;
  logic [23:0] signed_immediate;
  logic [11:0] shift_operand;
  logic        is_immediate, status_write_enable;
  logic [3:0]  execute_command;
  logic        mem_read, mem_write, wb_enable_out, is_branch;
  logic [3:0]  dest_reg;
  logic        two_src;

  id_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_in               (pc_in),
    .instruction         (instruction),
    .status_reg_in       (status_reg_in),
    .hazard              (hazard),
    .wb_enable           (wb_enable),
    .wb_dest             (wb_dest),
    .wb_value            (wb_value),
    .pc_out              (pc_out),
    .reg_file_src1       (reg_file_src1),
    .reg_file_src2       (reg_file_src2),
    .reg_file_out1       (reg_file_out1),
    .reg_file_out2       (reg_file_out2),
    .signed_immediate    (signed_immediate),
    .shift_operand       (shift_operand),
    .is_immediate        (is_immediate),
    .status_write_enable (status_write_enable),
    .execute_command     (execute_command),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .wb_enable_out       (wb_enable_out),
    .is_branch           (is_branch),
    .dest_reg            (dest_reg),
    .two_src             (two_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    logic        hz;
    logic [3:0]  ecmd;
    logic        wb, mr, mw, br, swe, two;
    logic [3:0]  s1, s2, dst;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] model [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_instr(input logic [3:0] a, input logic [3:0] b);
    return {4'hE, 3'b000, 4'b0100, 1'b0, a, 4'h0, 8'h00, b};
  endfunction

  task automatic read_check(input logic [3:0] idx);
    @(posedge clk); #1;
    instruction = rd_instr(idx, idx);
    @(negedge clk);
    chk($sformatf("rf_out1[%0d]", idx), reg_file_out1, (idx == 4'd15) ? 32'h0 : model[idx]);
    chk($sformatf("rf_out2[%0d]", idx), reg_file_out2, (idx == 4'd15) ? 32'h0 : model[idx]);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; pc_in = 32'h0; instruction = 32'h0; status_reg_in = 4'h0;
    hazard = 1'b0; wb_enable = 1'b0; wb_dest = 4'h0; wb_value = 32'h0;
    for (int i = 0; i < 15; i++) model[i] = 32'h0;

    //          instr         st    hz    ecmd  wb    mr    mw    br    swe   two   s1    s2    dst
    vecs.push_back('{32'hE0821003, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'h00821003, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'h00821003, 4'h4, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'hE5921004, 4'h0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h4, 4'h1});
    vecs.push_back('{32'hE5921004, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h4, 4'h1});
    vecs.push_back('{32'hE5821004, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 4'h1, 4'h1});
    vecs.push_back('{32'hEAFFFFFE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hE, 4'hF});
    vecs.push_back('{32'hE3A01005, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 4'h1});
    vecs.push_back('{32'hE1530004, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h4, 4'h0});
    vecs.push_back('{32'hF0821003, 4'hF, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'hE1E01002, 4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h2, 4'h1});
    vecs.push_back('{32'hEC000000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{32'hE0621003, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'hC0821003, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'hC0821003, 4'h8, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'hE0921003, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'hE0921003, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'h10921003, 4'h4, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'h80821003, 4'h2, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});
    vecs.push_back('{32'h80821003, 4'h6, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 4'h1});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: instruction 0 is AND EQ, gated off by Z=0.
    @(negedge clk);
    chk("rst_out1", reg_file_out1, 32'h0);
    chk("rst_wb_out", {31'h0, wb_enable_out}, 32'h0);
    chk("rst_ecmd", {28'h0, execute_command}, 32'h6);

    for (int i = 0; i < 15; i++) read_check(4'(i));

    // Decode table through the scoreboard.
    foreach (vecs[k]) begin
      @(posedge clk); #1;
      instruction   = vecs[k].instr;
      status_reg_in = vecs[k].status;
      hazard        = vecs[k].hz;
      pc_in         = 32'h1000 + 32'(k) * 32'd4;
      e.v  = vecs[k];
      e.pc = pc_in;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_ecmd", k), {28'h0, execute_command}, {28'h0, e.v.ecmd});
        chk($sformatf("v%0d_ctrl", k),
            {26'h0, wb_enable_out, mem_read, mem_write, is_branch, status_write_enable, two_src},
            {26'h0, e.v.wb, e.v.mr, e.v.mw, e.v.br, e.v.swe, e.v.two});
        chk($sformatf("v%0d_regs", k), {20'h0, reg_file_src1, reg_file_src2, dest_reg},
            {20'h0, e.v.s1, e.v.s2, e.v.dst});
        chk($sformatf("v%0d_imm", k), {7'h0, is_immediate, signed_immediate},
            {7'h0, e.v.instr[25], e.v.instr[23:0]});
        chk($sformatf("v%0d_shop", k), {20'h0, shift_operand}, {20'h0, e.v.instr[11:0]});
        chk($sformatf("v%0d_pc", k), pc_out, e.pc);
      end
    end
    status_reg_in = 4'h0; hazard = 1'b0;

    // Write every index including 15, then read all back.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      wb_enable = 1'b1;
      wb_dest   = 4'(i);
      wb_value  = (i == 15) ? 32'hFFFF_FFFF : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
      if (i < 15) model[i] = wb_value;
    end
    @(posedge clk); #1 wb_enable = 1'b0;
    for (int i = 0; i < 16; i++) read_check(4'(i));

    // Same-cycle write-through, then persistence after the edge.
    @(posedge clk); #1;
    wb_enable = 1'b1; wb_dest = 4'd3; wb_value = 32'h0000_1234;
    instruction = rd_instr(4'd3, 4'd7);
    @(negedge clk);
    chk("bypass_before", reg_file_out1, 32'h0000_1234);
    chk("bypass_other_port", reg_file_out2, model[7]);
    model[3] = 32'h0000_1234;
    @(posedge clk); #1 wb_enable = 1'b0;
    @(negedge clk);
    chk("bypass_after", reg_file_out1, 32'h0000_1234);

    // Write to 15 while reading 15 must still read zero.
    @(posedge clk); #1;
    wb_enable = 1'b1; wb_dest = 4'd15; wb_value = 32'hFFFF_FFFF;
    instruction = rd_instr(4'd15, 4'd15);
    @(negedge clk);
    chk("r15_bypass", reg_file_out1, 32'h0);
    @(posedge clk); #1 wb_enable = 1'b0;

    // Reset discards a coincident write and clears the file.
    @(posedge clk); #1;
    rst = 1'b1; wb_enable = 1'b1; wb_dest = 4'd5; wb_value = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0; wb_enable = 1'b0;
    for (int i = 0; i < 15; i++) model[i] = 32'h0;
    read_check(4'd5);
    read_check(4'd3);
    read_check(4'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
